csi2_delay_calib: RTL and testbench

//  Automatic per-lane IDELAY calibration controller for the CSI-2 receiver, on the pixel clock.

---
 rtl/csi2_calib_pkg.sv | 22 ++
 rtl/csi2_calib_window_tracker.sv | 68 ++++++
 rtl/csi2_delay_calib.sv | 213 +++++++++++++++++++++
 tb/tb_csi2_delay_calib.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_calib_pkg.sv
// Shared types and default-geometry constants for the CSI-2 lane delay calibrator.
// Optional eye map output is enabled by CSI2_DELAY_CALIB_EYE_MAP_EN.
package csi2_calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    MEASURE,
    EVAL,
    FINAL,
    DONE
  } calib_state_t;

  localparam int DEF_DELAY_WIDTH = 5;
  localparam int DEF_LANES       = 2;
  localparam int MAX_TAP         = 2**DEF_DELAY_WIDTH - 1;
  localparam int RUN_WIDTH       = DEF_DELAY_WIDTH + 1;

  typedef logic [DEF_LANES-1:0][DEF_DELAY_WIDTH-1:0] lane_taps_t;

endpackage

// File: rtl/csi2_calib_window_tracker.sv
// Tracks the longest run of good taps seen during one lane sweep.
// Earliest window wins ties; no wrap-around past the last tap.
module csi2_calib_window_tracker
  import csi2_calib_pkg::*;
#(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic                   good_i,
  input  logic [DELAY_WIDTH-1:0] tap_i,
  output logic [DELAY_WIDTH-1:0] best_start_o,
  output logic [DELAY_WIDTH:0]   best_len_o
);

  logic [DELAY_WIDTH:0]   run_len_q, run_len_d;
  logic [DELAY_WIDTH:0]   best_len_q, best_len_d;
  logic [DELAY_WIDTH-1:0] run_start_q, run_start_d;
  logic [DELAY_WIDTH-1:0] best_start_q, best_start_d;
  logic [DELAY_WIDTH:0]   rl;
  logic [DELAY_WIDTH-1:0] rs;

  always_comb begin
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    rl = run_len_q + 1'b1;
    rs = (run_len_q == '0) ? tap_i : run_start_q;
    if (clear_i) begin
      run_len_d    = '0;
      run_start_d  = '0;
      best_len_d   = '0;
      best_start_d = '0;
    end else if (valid_i) begin
      if (good_i) begin
        run_len_d   = rl;
        run_start_d = rs;
        if (rl > best_len_q) begin
          best_len_d   = rl;
          best_start_d = rs;
        end
      end else begin
        run_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else begin
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/csi2_delay_calib.sv
// Per-lane IDELAY sweep: score each tap by errors, centre each lane in its widest clean window.
// Define CSI2_DELAY_CALIB_EYE_MAP_EN to add the per-tap eye_map_o result bitmap.
module csi2_delay_calib
  import csi2_calib_pkg::*;
#(
  parameter int DATA_LANES     = 2,
  parameter int DELAY_WIDTH    = 5,
  parameter int INIT_DELAY     = 0,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DWELL_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 2**22,
  parameter int MIN_WINDOW     = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic                                  abort_i,
  input  logic                                  frame_start_i,
  input  logic                                  header_err_i,
  input  logic                                  crc_err_i,
  output logic [DATA_LANES-1:0][DELAY_WIDTH-1:0] lane_delay_o,
  output logic                                  delay_act_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [DATA_LANES-1:0]                 lane_fail_o
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
  ,
  output logic [DATA_LANES-1:0][2**DELAY_WIDTH-1:0] eye_map_o
`endif
);

  localparam int TAP_MAX = 2**DELAY_WIDTH - 1;
  localparam int RUN_W   = DELAY_WIDTH + 1;
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
  localparam int FR_W    = $clog2(DWELL_FRAMES + 1);
  localparam int LANE_W  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;

  calib_state_t state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DELAY_WIDTH-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FR_W-1:0] fr_q, fr_d, fr_n;
  logic err_q, err_d, err_n;
  logic good_q, good_d;
  logic [DATA_LANES-1:0][DELAY_WIDTH-1:0] taps_q, taps_d;
  logic act_q, act_d;
  logic done_q, done_d;
  logic [DATA_LANES-1:0] fail_q, fail_d;
  logic trk_clear, trk_valid;
  logic [DELAY_WIDTH-1:0] best_start;
  logic [RUN_W-1:0] best_len;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
  logic [DATA_LANES-1:0][2**DELAY_WIDTH-1:0] eye_q, eye_d;
`endif

  csi2_calib_window_tracker #(
    .DELAY_WIDTH(DELAY_WIDTH)
  ) u_trk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (trk_clear),
    .valid_i     (trk_valid),
    .good_i      (good_q),
    .tap_i       (tap_q),
    .best_start_o(best_start),
    .best_len_o  (best_len)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tap_d     = tap_q;
    cnt_d     = cnt_q;
    fr_d      = fr_q;
    err_d     = err_q;
    good_d    = good_q;
    taps_d    = taps_q;
    act_d     = 1'b0;
    done_d    = 1'b0;
    fail_d    = fail_q;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
    eye_d     = eye_q;
`endif
    fr_n  = fr_q + FR_W'(frame_start_i);
    err_n = err_q | header_err_i | crc_err_i;
    // Abort freezes everything already loaded; only the FSM returns home.
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d   = APPLY;
            lane_d    = '0;
            tap_d     = '0;
            fail_d    = '0;
            trk_clear = 1'b1;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
            eye_d     = '0;
`endif
          end
        end
        APPLY: begin
          taps_d[lane_q] = tap_q;
          act_d   = 1'b1;
          cnt_d   = '0;
          fr_d    = '0;
          err_d   = 1'b0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          fr_d  = fr_n;
          err_d = err_n;
          cnt_d = cnt_q + 1'b1;
          if (fr_n == FR_W'(DWELL_FRAMES) ||
              cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            good_d  = (fr_n == FR_W'(DWELL_FRAMES)) && !err_n;
            state_d = EVAL;
          end
        end
        EVAL: begin
          trk_valid = 1'b1;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
          eye_d[lane_q][tap_q] = good_q;
`endif
          if (tap_q == DELAY_WIDTH'(TAP_MAX)) begin
            state_d = FINAL;
          end else begin
            tap_d   = tap_q + 1'b1;
            state_d = APPLY;
          end
        end
        FINAL: begin
          trk_clear = 1'b1;
          act_d     = 1'b1;
          if (best_len >= RUN_W'(MIN_WINDOW)) begin
            taps_d[lane_q] =
              DELAY_WIDTH'(best_start + ((best_len - 1'b1) >> 1));
          end else begin
            taps_d[lane_q] = DELAY_WIDTH'(INIT_DELAY);
            fail_d[lane_q] = 1'b1;
          end
          if (lane_q == LANE_W'(DATA_LANES - 1)) begin
            state_d = DONE;
          end else begin
            lane_d  = lane_q + 1'b1;
            tap_d   = '0;
            state_d = APPLY;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lane_q  <= '0;
      tap_q   <= '0;
      cnt_q   <= '0;
      fr_q    <= '0;
      err_q   <= 1'b0;
      good_q  <= 1'b0;
      taps_q  <= {DATA_LANES{DELAY_WIDTH'(INIT_DELAY)}};
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= '0;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
      eye_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      fr_q    <= fr_d;
      err_q   <= err_d;
      good_q  <= good_d;
      taps_q  <= taps_d;
      act_q   <= act_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
      eye_q   <= eye_d;
`endif
    end
  end

  assign lane_delay_o = taps_q;
  assign delay_act_o  = act_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign lane_fail_o  = fail_q;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
  assign eye_map_o    = eye_q;
`endif

endmodule

// File: tb/tb_csi2_delay_calib.sv
// Bench for csi2_delay_calib: a channel model injects errors per swept tap,
// and a scoreboard checks every final tap load and every done_o pulse.
module tb_csi2_delay_calib;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst_i, start_i, abort_i;
  logic frame_start_i, header_err_i, crc_err_i;
  logic [1:0][4:0] lane_delay_o;
  logic delay_act_o, busy_o, done_o;
  logic [1:0] lane_fail_o;
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
  logic [1:0][31:0] eye_map_o;
`endif

  csi2_delay_calib #(
    .DATA_LANES    (2),
    .DELAY_WIDTH   (5),
    .INIT_DELAY    (0),
    .SETTLE_CYCLES (SETTLE),
    .DWELL_FRAMES  (2),
    .TIMEOUT_CYCLES(TIMEOUT),
    .MIN_WINDOW    (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .frame_start_i(frame_start_i),
    .header_err_i (header_err_i),
    .crc_err_i    (crc_err_i),
    .lane_delay_o (lane_delay_o),
    .delay_act_o  (delay_act_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .lane_fail_o  (lane_fail_o)
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
    ,
    .eye_map_o    (eye_map_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0][4:0] taps;
    logic [1:0]      fail;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] tap_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since = 1000;
  int pidx = 0;
  int cur_lane = 0;
  int cur_tap = 32;
  int last_pulse = 0;
  int last_gap = 0;
  int done_seen = 0;
  int done_pidx = 0;
  bit frames_en = 1'b1;
  logic [31:0] good_mask [2];

  // Each sweep issues 33 loads per lane: taps 0..31 then the final centre.
  task automatic tick();
    exp_t e;
    logic [4:0] t;
    @(negedge clk);
    cyc++;
    since++;
    if (done_o) begin
      done_seen++;
      done_pidx = pidx;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done_o taps %h fail %b, none expected",
                 lane_delay_o, lane_fail_o);
      end else begin
        e = exp_q.pop_front();
        if ({lane_delay_o, lane_fail_o} !== {e.taps, e.fail}) begin
          errors++;
          $display("FAIL done_result: got taps %h fail %b, expected taps %h fail %b",
                   lane_delay_o, lane_fail_o, e.taps, e.fail);
        end
      end
    end
    if (!busy_o) pidx = 0;
    if (delay_act_o) begin
      cur_lane = pidx / 33;
      cur_tap = pidx % 33;
      last_gap = cyc - last_pulse;
      last_pulse = cyc;
      since = 0;
      pidx++;
      if (cur_tap == 32 && cur_lane < 2) begin
        checks++;
        if (tap_q.size() == 0) begin
          errors++;
          $display("FAIL final_tap_unexpected: lane %0d loaded %0d",
                   cur_lane, lane_delay_o[cur_lane]);
        end else begin
          t = tap_q.pop_front();
          if (lane_delay_o[cur_lane] !== t) begin
            errors++;
            $display("FAIL final_tap: lane %0d got %0d expected %0d",
                     cur_lane, lane_delay_o[cur_lane], t);
          end
        end
      end
    end
    frame_start_i = frames_en && since >= 6 && ((since - 6) % 10 == 0);
    crc_err_i = frame_start_i && since == 16 && cur_lane < 2 &&
                cur_tap < 32 && !good_mask[cur_lane][cur_tap];
    header_err_i = (since == 1);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit hit);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < limit && done_seen == d0; i++) tick();
    hit = (done_seen != d0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (lane_delay_o !== 10'h000) begin
      errors++;
      $display("FAIL reset_taps: got %h expected 000", lane_delay_o);
    end
    checks++;
    if ({delay_act_o, busy_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: act/busy/done got %b expected 000",
               {delay_act_o, busy_o, done_o});
    end
    checks++;
    if (lane_fail_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_fail: got %b expected 00", lane_fail_o);
    end
  endtask

  task automatic test_sweep_window();
    bit hit;
    int d0;
    good_mask[0] = 32'h000F_FF00;
    good_mask[1] = 32'h000F_FF00;
    tap_q.push_back(5'd13);
    tap_q.push_back(5'd13);
    exp_q.push_back('{taps: {5'd13, 5'd13}, fail: 2'b00});
    d0 = done_seen;
    pulse_start();
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL sweep_busy: got %b expected 1", busy_o);
    end
    wait_done(4000, hit);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL sweep_timeout: done_o not seen, got 0 expected 1");
    end
    repeat (20) tick();
    checks++;
    if (done_seen - d0 != 1 || exp_q.size() != 0 || tap_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_done_once: got %0d dones, pending %0d/%0d, expected 1,0/0",
               done_seen - d0, exp_q.size(), tap_q.size());
    end
`ifdef CSI2_DELAY_CALIB_EYE_MAP_EN
    checks++;
    if (eye_map_o !== {good_mask[1], good_mask[0]}) begin
      errors++;
      $display("FAIL eye_map: got %h expected %h",
               eye_map_o, {good_mask[1], good_mask[0]});
    end
`endif
  endtask

  task automatic test_all_clean();
    bit hit;
    good_mask[0] = 32'hFFFF_FFFF;
    good_mask[1] = 32'hFFFF_FFFF;
    tap_q.push_back(5'd15);
    tap_q.push_back(5'd15);
    exp_q.push_back('{taps: {5'd15, 5'd15}, fail: 2'b00});
    pulse_start();
    wait_done(4000, hit);
    checks++;
    if (!hit || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clean_done: got hit %0d pending %0d expected 1,0",
               hit, exp_q.size());
    end
  endtask

  task automatic test_narrow_fail();
    bit hit;
    good_mask[0] = 32'h0000_0C18;
    good_mask[1] = 32'h0000_0C18;
    tap_q.push_back(5'd0);
    tap_q.push_back(5'd0);
    exp_q.push_back('{taps: {5'd0, 5'd0}, fail: 2'b11});
    pulse_start();
    wait_done(4000, hit);
    checks++;
    if (!hit || exp_q.size() != 0) begin
      errors++;
      $display("FAIL narrow_done: got hit %0d pending %0d expected 1,0",
               hit, exp_q.size());
    end
  endtask

  task automatic test_tie();
    bit hit;
    good_mask[0] = 32'h0000_1E3C;
    good_mask[1] = 32'hFFFF_FFFF;
    tap_q.push_back(5'd3);
    tap_q.push_back(5'd15);
    exp_q.push_back('{taps: {5'd15, 5'd3}, fail: 2'b00});
    pulse_start();
    checks++;
    if (lane_fail_o !== 2'b00) begin
      errors++;
      $display("FAIL tie_fail_cleared: got %b expected 00", lane_fail_o);
    end
    wait_done(4000, hit);
    checks++;
    if (!hit || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tie_done: got hit %0d pending %0d expected 1,0",
               hit, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit hit;
    frames_en = 1'b0;
    tap_q.push_back(5'd0);
    tap_q.push_back(5'd0);
    exp_q.push_back('{taps: {5'd0, 5'd0}, fail: 2'b11});
    pulse_start();
    wait_done(6000, hit);
    checks++;
    if (!hit || done_pidx != 66) begin
      errors++;
      $display("FAIL timeout_loads: got hit %0d loads %0d expected 1,66",
               hit, done_pidx);
    end
    checks++;
    if (last_gap != 2 + SETTLE + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_gap: got %0d cycles expected %0d",
               last_gap, 2 + SETTLE + TIMEOUT);
    end
    frames_en = 1'b1;
  endtask

  task automatic test_abort();
    int d0;
    good_mask[0] = 32'h000F_FF00;
    good_mask[1] = 32'h000F_FF00;
    tap_q.push_back(5'd13);
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 3000 && pidx != 39; i++) tick();
    repeat (8) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", busy_o);
    end
    checks++;
    if (lane_delay_o !== {5'd5, 5'd13}) begin
      errors++;
      $display("FAIL abort_taps: got %h expected %h", lane_delay_o, {5'd5, 5'd13});
    end
    repeat (100) tick();
    checks++;
    if (done_seen != d0 || busy_o !== 1'b0 || tap_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_done: got dones %0d busy %b pending %0d expected 0,0,0",
               done_seen - d0, busy_o, tap_q.size());
    end
  endtask

  task automatic test_start_abort_same();
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_same: busy got %b expected 0", busy_o);
    end
  endtask

  task automatic test_restart_ignored();
    int d0;
    good_mask[0] = 32'h000F_FF00;
    good_mask[1] = 32'h000F_FF00;
    tap_q.push_back(5'd13);
    tap_q.push_back(5'd13);
    exp_q.push_back('{taps: {5'd13, 5'd13}, fail: 2'b00});
    d0 = done_seen;
    pulse_start();
    for (int i = 0; i < 4000 && done_seen == d0; i++) begin
      start_i = (i == 200 || i == 900);
      tick();
    end
    start_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (done_seen - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_ignored: got dones %0d pending %0d expected 1,0",
               done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    good_mask[0] = 32'h0000_0C18;
    good_mask[1] = 32'hFFFF_FFFF;
    tap_q.push_back(5'd0);
    pulse_start();
    for (int i = 0; i < 3000 && pidx < 45; i++) tick();
    checks++;
    if (lane_fail_o !== 2'b01 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: fail got %b busy %b expected 01,1", lane_fail_o, busy_o);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if ({lane_delay_o, delay_act_o, busy_o, done_o, lane_fail_o} !== 15'h0) begin
      errors++;
      $display("FAIL mid_reset: got taps %h act %b busy %b done %b fail %b expected all 0",
               lane_delay_o, delay_act_o, busy_o, done_o, lane_fail_o);
    end
    rst_i = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    frame_start_i = 1'b0;
    header_err_i = 1'b0;
    crc_err_i = 1'b0;
    good_mask[0] = '0;
    good_mask[1] = '0;
    test_reset();
    test_sweep_window();
    test_all_clean();
    test_narrow_fail();
    test_tie();
    test_timeout();
    test_abort();
    test_start_abort_same();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
